// File: rtl/uart_frame_decoder.sv
// Flag-delimited UART frame decoder: unstuffs bytes, checks address/length/CRC-16,
// and streams payload through a FWFT FIFO tagged with address and last flag.
module uart_frame_decoder #(
  parameter logic [7:0] FLAG       = 8'h7E,
  parameter logic [7:0] ESC        = 8'h7D,
  parameter int         N_CH       = 4,
  parameter int         MAX_LEN    = 255,
  parameter bit         CRC_EN     = 1'b1,
  parameter int         FIFO_DEPTH = 16,
  parameter int         TIMEOUT    = 100000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          new_data_rx,
  input  logic [7:0]                    data_rx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic [7:0]                    out_addr,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic [2:0]                    err_code,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CRC_H, S_CRC_L, S_END} state_t;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } fifo_ent_t;

  state_t          state_q, state_n, after_len;
  logic            esc_q;
  logic [7:0]      ub;
  logic            is_flag, is_esc, byte_v, tmo;
  logic [2:0]      err_lat_q, err_new, rep_code;
  logic            open_frm, close_ok, close_err;
  logic [7:0]      addr_q, cnt_q, crch_q;
  logic [15:0]     crc_q;
  logic [TW-1:0]   idle_q;
  logic            push_req, push_ok, pop, full;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q;
  fifo_ent_t       mem [FIFO_DEPTH];
  fifo_ent_t       head;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // A FLAG always delimits, even right after ESC; the escape latch only affects data bytes.
  assign ub      = esc_q ? (data_rx ^ 8'h20) : data_rx;
  assign is_flag = new_data_rx && (data_rx == FLAG);
  assign is_esc  = new_data_rx && (data_rx == ESC) && !esc_q && (state_q != S_IDLE);
  assign byte_v  = new_data_rx && !is_flag && !is_esc && (state_q != S_IDLE);
  assign tmo     = (state_q != S_IDLE) && !new_data_rx && (idle_q == TW'(TIMEOUT - 1));
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push_ok = push_req && !full;
  assign pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_n;

  always_comb begin
    state_n   = state_q;
    after_len = CRC_EN ? S_CRC_H : S_END;
    err_new   = 3'd0;
    rep_code  = err_lat_q;
    open_frm  = 1'b0;
    close_ok  = 1'b0;
    close_err = 1'b0;
    push_req  = 1'b0;
    if (tmo) begin
      state_n   = S_IDLE;
      close_err = 1'b1;
      if (err_lat_q == 3'd0) rep_code = 3'd7;
    end else begin
      case (state_q)
        S_IDLE: if (is_flag) begin
          state_n  = S_ADDR;
          open_frm = 1'b1;
        end
        S_END: begin
          if (is_flag) begin
            state_n   = S_IDLE;
            close_ok  = (err_lat_q == 3'd0);
            close_err = (err_lat_q != 3'd0);
          end else if (byte_v) err_new = 3'd5;
        end
        default: begin
          // Early flag: abort this frame and reuse the flag as the next opener.
          if (is_flag) begin
            state_n   = S_ADDR;
            open_frm  = 1'b1;
            close_err = 1'b1;
            if (err_lat_q == 3'd0) rep_code = 3'd4;
          end else if (byte_v) begin
            case (state_q)
              S_ADDR: begin
                if ({1'b0, ub} >= 9'(N_CH)) err_new = 3'd1;
                state_n = S_LEN;
              end
              S_LEN: begin
                if (ub > 8'(MAX_LEN)) err_new = 3'd2;
                state_n = (ub == 8'd0) ? after_len : S_DATA;
              end
              S_DATA: begin
                push_req = (err_lat_q == 3'd0);
                if (cnt_q == 8'd1) state_n = after_len;
              end
              S_CRC_H: state_n = S_CRC_L;
              S_CRC_L: begin
                if ({crch_q, ub} != crc_q) err_new = 3'd3;
                state_n = S_END;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
    if (push_req && full) err_new = 3'd6;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      esc_q      <= 1'b0;
      err_lat_q  <= 3'd0;
      addr_q     <= 8'd0;
      cnt_q      <= 8'd0;
      crch_q     <= 8'd0;
      crc_q      <= 16'hFFFF;
      idle_q     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      frame_done <= close_ok;
      frame_err  <= close_err;
      if (close_ok)       err_code <= 3'd0;
      else if (close_err) err_code <= rep_code;

      if (is_esc)                  esc_q <= 1'b1;
      else if (new_data_rx || tmo) esc_q <= 1'b0;

      if (new_data_rx || state_q == S_IDLE) idle_q <= '0;
      else if (!tmo)                        idle_q <= idle_q + 1'b1;

      // First error wins; a new frame clears the latch and reseeds the CRC.
      if (open_frm) begin
        err_lat_q <= 3'd0;
        crc_q     <= 16'hFFFF;
      end else begin
        if (err_new != 3'd0 && err_lat_q == 3'd0) err_lat_q <= err_new;
        if (byte_v && (state_q == S_ADDR || state_q == S_LEN || state_q == S_DATA))
          crc_q <= crc_upd(crc_q, ub);
      end

      if (byte_v && state_q == S_ADDR && {1'b0, ub} < 9'(N_CH)) addr_q <= ub;
      if (byte_v && state_q == S_LEN)   cnt_q  <= ub;
      if (byte_v && state_q == S_DATA)  cnt_q  <= cnt_q - 8'd1;
      if (byte_v && state_q == S_CRC_H) crch_q <= ub;
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wptr_q] <= {addr_q, ub, (cnt_q == 8'd1)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Head is masked while empty so outputs read zero out of reset.
  assign head       = mem[rptr_q];
  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? head.data : 8'd0;
  assign out_addr   = out_valid ? head.addr : 8'd0;
  assign out_last   = out_valid & head.last;
  assign busy       = (state_q != S_IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Bench for uart_frame_decoder: table of frames plus hand sequences, scoreboarded payload and frame events.
module tb_uart_frame_decoder;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ESC  = 8'h7D;
  localparam int TMO   = 60;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NV    = 8;

  logic          clk = 1'b0;
  logic          rstn, new_data_rx, out_ready, out_valid, out_last, frame_done, frame_err, busy;
  logic [7:0]    data_rx, out_data, out_addr;
  logic [2:0]    err_code;
  logic [LW-1:0] fifo_level;

  int          n_tests = 0, n_fail = 0;
  logic [16:0] exp_q [$];
  logic [2:0]  ev_q [$];
  logic [7:0]  pl [0:31];
  logic [15:0] c;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [7:0]  seed;
    logic [15:0] crc_x;
    bit          hold;
    logic [2:0]  code;
    int          n_push;
  } vec_t;
  vec_t vt [NV];
  vec_t v;

  uart_frame_decoder #(.FLAG(FLAG), .ESC(ESC), .N_CH(4), .MAX_LEN(255), .CRC_EN(1'b1),
                       .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .new_data_rx(new_data_rx), .data_rx(data_rx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .busy(busy), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial reference CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_bit(input logic [15:0] ci, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = ci;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  always @(negedge clk) if (rstn) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_byte", {out_addr, out_data, out_last}, 32'h1_FFFF);
      else chk("sb_byte", {out_addr, out_data, out_last}, exp_q.pop_front());
    end
    if (frame_done || frame_err) begin
      if (ev_q.size() == 0) chk("evt_unexpected", {frame_done, frame_err, err_code}, 0);
      else begin
        logic [2:0] e;
        e = ev_q.pop_front();
        chk("frame_evt", {frame_done, frame_err, err_code}, {(e == 3'd0), (e != 3'd0), e});
      end
    end
  end

  // Called at #1 after a posedge; leaves the bench at #1 after the next posedge.
  task automatic send_raw(input logic [7:0] b);
    new_data_rx = 1'b1;
    data_rx     = b;
    @(posedge clk); #1;
    new_data_rx = 1'b0;
  endtask

  task automatic send_st(input logic [7:0] b);
    if (b == FLAG || b == ESC) begin
      send_raw(ESC);
      send_raw(b ^ 8'h20);
    end else send_raw(b);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input bit open,
                            input logic [15:0] crc_x);
    logic [15:0] cc;
    cc = 16'hFFFF;
    if (open) send_raw(FLAG);
    send_st(a); cc = crc_bit(cc, a);
    send_st(l); cc = crc_bit(cc, l);
    for (int i = 0; i < int'(l); i++) begin
      send_st(pl[i]);
      cc = crc_bit(cc, pl[i]);
    end
    cc = cc ^ crc_x;
    send_st(cc[15:8]);
    send_st(cc[7:0]);
    send_raw(FLAG);
  endtask

  task automatic exp_payload(input logic [7:0] a, input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({a, pl[i], (i == int'(l) - 1)});
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, exp_q.size() + ev_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          addr   len    seed   crc_x     hold  code  n_push
    vt[0] = '{8'd0, 8'd1,  8'h10, 16'h0000, 1'b0, 3'd0, 1};
    vt[1] = '{8'd3, 8'd8,  8'h77, 16'h0000, 1'b0, 3'd0, 8};
    vt[2] = '{8'd2, 8'd0,  8'h00, 16'h0000, 1'b0, 3'd0, 0};
    vt[3] = '{8'd1, 8'd5,  8'h20, 16'h0001, 1'b0, 3'd3, 5};
    vt[4] = '{8'd4, 8'd3,  8'h30, 16'h0000, 1'b0, 3'd1, 0};
    vt[5] = '{8'd2, 8'd10, 8'h5A, 16'h0000, 1'b1, 3'd0, 10};
    vt[6] = '{8'd0, 8'd16, 8'h01, 16'h0000, 1'b1, 3'd0, 16};
    vt[7] = '{8'd1, 8'd20, 8'h40, 16'h0000, 1'b1, 3'd6, 16};

    rstn = 1'b0; new_data_rx = 1'b0; data_rx = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_data, out_addr, out_last, frame_done, frame_err,
                          err_code, busy, fifo_level}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reference frame with latency and pulse timing checks.
    pl[0] = 8'hAA; pl[1] = 8'h99; pl[2] = 8'h55; pl[3] = 8'h66;
    exp_payload(8'h01, 8'd4, 4);
    ev_q.push_back(3'd0);
    out_ready = 1'b0;
    send_raw(FLAG);
    chk("busy_after_open", busy, 1);
    c = crc_bit(16'hFFFF, 8'h01);
    send_st(8'h01);
    c = crc_bit(c, 8'h04);
    send_st(8'h04);
    chk("empty_before_payload", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      send_st(pl[i]);
      c = crc_bit(c, pl[i]);
      if (i == 0) chk("valid_n_plus_1", out_valid, 1);
    end
    send_st(c[15:8]);
    send_st(c[7:0]);
    send_raw(FLAG);
    chk("done_pulse", {frame_done, frame_err, busy}, 3'b100);
    @(posedge clk); #1;
    chk("done_one_cycle", frame_done, 0);
    out_ready = 1'b1;
    wait_idle("drain_ref");
    chk("ref_errcode", err_code, 0);

    // Stuffed payload 7E 7D.
    pl[0] = 8'h7E; pl[1] = 8'h7D;
    exp_payload(8'h02, 8'd2, 2);
    ev_q.push_back(3'd0);
    send_frame(8'h02, 8'd2, 1'b1, 16'h0000);
    wait_idle("drain_stuff");

    for (int t = 0; t < NV; t++) begin
      v = vt[t];
      for (int i = 0; i < 32; i++) pl[i] = v.seed + 8'(i * 37);
      exp_payload(v.addr, v.len, v.n_push);
      ev_q.push_back(v.code);
      out_ready = !v.hold;
      send_frame(v.addr, v.len, 1'b1, v.crc_x);
      if (v.hold) begin
        chk($sformatf("level_%0d", t), fifo_level, v.n_push);
        out_ready = 1'b1;
      end
      wait_idle($sformatf("drain_%0d", t));
      chk($sformatf("errcode_%0d", t), {busy, err_code}, {1'b0, v.code});
    end

    // Timeout mid-payload.
    pl[0] = 8'h11; pl[1] = 8'h22;
    exp_payload(8'h01, 8'd4, 2);
    ev_q.push_back(3'd7);
    send_raw(FLAG); send_st(8'h01); send_st(8'h04); send_st(8'h11); send_st(8'h22);
    repeat (TMO - 2) begin @(posedge clk); #1; end
    chk("no_early_timeout", busy, 1);
    wait_idle("timeout_evt");
    chk("timeout_state", {busy, err_code}, {1'b0, 3'd7});

    // Early flag mid-DATA, then the flag opens a good frame.
    pl[0] = 8'h33;
    exp_payload(8'h02, 8'd4, 1);
    ev_q.push_back(3'd4);
    send_raw(FLAG); send_st(8'h02); send_st(8'h04); send_st(8'h33);
    send_raw(FLAG);
    chk("abort_pulse", {frame_err, err_code, busy}, {1'b1, 3'd4, 1'b1});
    pl[0] = 8'h44; pl[1] = 8'h55;
    exp_payload(8'h01, 8'd2, 2);
    ev_q.push_back(3'd0);
    send_frame(8'h01, 8'd2, 1'b0, 16'h0000);
    wait_idle("after_abort");
    chk("after_abort_code", err_code, 0);

    // Reset during DATA with bytes held in the FIFO.
    out_ready = 1'b0;
    send_raw(FLAG); send_st(8'h01); send_st(8'h05); send_st(8'hA1); send_st(8'hA2);
    chk("held_before_reset", fifo_level, 2);
    rstn = 1'b0;
    #1;
    chk("midframe_reset", {out_valid, out_data, out_addr, out_last, frame_done, frame_err,
                           err_code, busy, fifo_level}, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) pl[i] = 8'hC0 + 8'(i);
    exp_payload(8'h03, 8'd3, 3);
    ev_q.push_back(3'd0);
    send_frame(8'h03, 8'd3, 1'b1, 16'h0000);
    wait_idle("post_reset_frame");
    chk("post_reset_code", {busy, err_code, fifo_level}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
